// File: rtl/mtimer_sched_pkg.sv
// Shared types and constants for the mtimer alarm scheduler.
package mtimer_sched_pkg;

  localparam int MTIME_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WAIT = 2'd2,
    FIRE = 2'd3
  } sched_state_t;

  localparam logic ARM    = 1'b0;
  localparam logic CANCEL = 1'b1;

endpackage

// File: rtl/mtimer_prescaler.sv
// Clock prescaler: counts 0..DIV-1 and pulses tick on the last count.
// The halt input exists only when MTIMER_SCHED_HALT_EN is defined.
module mtimer_prescaler #(
  parameter int DIV = 50
) (
  input  logic clock,
  input  logic reset,
`ifdef MTIMER_SCHED_HALT_EN
  input  logic halt,
`endif
  output logic tick
);

  localparam int DIV_EFF = (DIV < 1) ? 1 : DIV;
  localparam int CW      = (DIV_EFF > 1) ? $clog2(DIV_EFF) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_EFF - 1);

  logic [CW-1:0] cnt;
  logic          run;

`ifdef MTIMER_SCHED_HALT_EN
  assign run = !halt;
`else
  assign run = 1'b1;
`endif

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mtimer_alarm_scheduler.sv
// Machine-timer alarm scheduler: NUM_SLOTS alarms, earliest deadline fires first.
// Defining MTIMER_SCHED_HALT_EN adds a halt input that freezes mtime.
//
// state | meaning
// IDLE  | no slot armed, waiting for a command
// SCAN  | walking the slots one per cycle to find the earliest deadline
// WAIT  | earliest deadline latched, comparing against mtime
// FIRE  | presenting fire_slot until fire_ready
module mtimer_alarm_scheduler
  import mtimer_sched_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int TICK_FREQUENCY  = 1000000,
  parameter int NUM_SLOTS       = 4,
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
`ifdef MTIMER_SCHED_HALT_EN
  input  logic                   halt,
`endif
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_op,
  input  logic [SW-1:0]          cmd_slot,
  input  logic [MTIME_WIDTH-1:0] cmd_deadline,
  output logic                   fire_valid,
  input  logic                   fire_ready,
  output logic [SW-1:0]          fire_slot,
  output logic [MTIME_WIDTH-1:0] mtime,
  output logic                   busy
);

  localparam int DIV = CLOCK_FREQUENCY / TICK_FREQUENCY;

  sched_state_t           state, state_nxt;
  logic [NUM_SLOTS-1:0]   slot_valid;
  logic [MTIME_WIDTH-1:0] slot_dl [NUM_SLOTS];
  logic [SW-1:0]          scan_idx, best_slot, cand_slot, tgt_slot;
  logic [MTIME_WIDTH-1:0] best_dl, cand_dl, tgt_dl;
  logic                   best_found, cand_found;
  logic                   tick, cmd_acc, fire_acc, scan_last;

  mtimer_prescaler #(.DIV(DIV)) u_prescaler (
    .clock (clock),
    .reset (reset),
`ifdef MTIMER_SCHED_HALT_EN
    .halt  (halt),
`endif
    .tick  (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) mtime <= '0;
    else if (tick) mtime <= mtime + 1'b1;
  end

  assign cmd_ready  = (state == IDLE) || (state == WAIT);
  assign cmd_acc    = cmd_valid && cmd_ready;
  assign fire_valid = (state == FIRE);
  assign fire_acc   = fire_valid && fire_ready;
  assign fire_slot  = tgt_slot;
  assign busy       = |slot_valid;
  assign scan_last  = (scan_idx == SW'(NUM_SLOTS - 1));

  // Strict less-than while scanning upward keeps the lowest index on ties.
  always_comb begin
    cand_found = best_found;
    cand_slot  = best_slot;
    cand_dl    = best_dl;
    if (slot_valid[scan_idx] && (!best_found || (slot_dl[scan_idx] < best_dl))) begin
      cand_found = 1'b1;
      cand_slot  = scan_idx;
      cand_dl    = slot_dl[scan_idx];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_acc) state_nxt = SCAN;
      SCAN: if (scan_last) state_nxt = cand_found ? WAIT : IDLE;
      WAIT: begin
        if (cmd_acc)              state_nxt = SCAN;
        else if (mtime >= tgt_dl) state_nxt = FIRE;
      end
      FIRE: if (fire_ready) state_nxt = SCAN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_valid <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_dl[i] <= '0;
      scan_idx   <= '0;
      best_found <= 1'b0;
      best_slot  <= '0;
      best_dl    <= '0;
      tgt_slot   <= '0;
      tgt_dl     <= '0;
    end else begin
      if (cmd_acc) begin
        if (cmd_op == ARM) begin
          slot_valid[cmd_slot] <= 1'b1;
          slot_dl[cmd_slot]    <= cmd_deadline;
        end else begin
          slot_valid[cmd_slot] <= 1'b0;
        end
      end else if (fire_acc) begin
        slot_valid[tgt_slot] <= 1'b0;
      end

      if (state == SCAN) begin
        scan_idx   <= scan_idx + 1'b1;
        best_found <= cand_found;
        best_slot  <= cand_slot;
        best_dl    <= cand_dl;
        if (scan_last && cand_found) begin
          tgt_slot <= cand_slot;
          tgt_dl   <= cand_dl;
        end
      end else begin
        scan_idx   <= '0;
        best_found <= 1'b0;
      end
    end
  end

endmodule
